// File: rtl/lsu_dccm_mem_rsp_pkg.sv
// Shared types and address-geometry helpers for the DCCM responder model.
// dccm_word_t is the ECC-wide storage word: {ecc[6:0], data[31:0]}.
package lsu_dccm_mem_rsp_pkg;

  localparam int unsigned DCCM_FDATA_W = 39;

  // Bank-select width for a power-of-two bank count
  function automatic int unsigned dccm_bank_bits(input int unsigned num_banks);
    return $clog2(num_banks);
  endfunction

  // Words per bank: the address bits left above the bank and byte fields
  function automatic int unsigned dccm_index_depth(input int unsigned bits,
                                                   input int unsigned num_banks);
    return 2 ** (bits - 2 - dccm_bank_bits(num_banks));
  endfunction

  // Default geometry: 16-bit byte address, 8 banks
  localparam int unsigned DCCM_BANK_BITS   = dccm_bank_bits(8);
  localparam int unsigned DCCM_INDEX_DEPTH = dccm_index_depth(16, 8);

  typedef enum logic {INIT, RUN} dccm_fsm_t;

  typedef logic [DCCM_FDATA_W-1:0] dccm_word_t;

endpackage

// File: rtl/lsu_dccm_bank.sv
// One DCCM bank: DEPTH x W storage, one write port and two registered read
// ports (lo/hi). A read in the same cycle as a write to the same index
// returns the pre-write contents.
// Ports: clk, rst, wr_en/wr_idx/wr_data, rd_en_lo/rd_idx_lo, rd_en_hi/rd_idx_hi,
//        rd_data_lo/rd_data_hi (registered, hold when not enabled).
module lsu_dccm_bank #(
  parameter int unsigned IDX_BITS = 9,
  parameter int unsigned DEPTH    = 512,
  parameter int unsigned W        = 39
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [IDX_BITS-1:0] wr_idx,
  input  logic [W-1:0]        wr_data,
  input  logic                rd_en_lo,
  input  logic [IDX_BITS-1:0] rd_idx_lo,
  input  logic                rd_en_hi,
  input  logic [IDX_BITS-1:0] rd_idx_hi,
  output logic [W-1:0]        rd_data_lo,
  output logic [W-1:0]        rd_data_hi
);

  logic [W-1:0] mem [DEPTH];

  // Storage has no reset; the top-level sweep clears it
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end

  // Registered read ports
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_lo <= '0;
      rd_data_hi <= '0;
    end else begin
      if (rd_en_lo) rd_data_lo <= mem[rd_idx_lo];
      if (rd_en_hi) rd_data_hi <= mem[rd_idx_hi];
    end
  end

endmodule

// File: rtl/lsu_dccm_mem_rsp.sv
// DCCM responder: banked ECC-word storage answering one write and two reads
// (lo/hi) per cycle with read latency 1. After reset an INIT sweep writes a
// zero codeword to every index of every bank; requests are ignored meanwhile.
// dccm_collision_err flags a same-bank write+read in the previous cycle.
// Optional macro RV_DCCM_ECC_INJECT_EN: inj_vld arms an XOR mask that is applied
// to the next lo read result only (storage is untouched).
// Ports: clk, rst, dccm_wren/wr_addr/wr_data, dccm_rden/rd_addr_lo/rd_addr_hi,
//        dccm_rd_data_lo/hi, dccm_init_busy, dccm_collision_err,
//        inj_vld/inj_mask/inj_pending.
module lsu_dccm_mem_rsp
  import lsu_dccm_mem_rsp_pkg::*;
#(
  parameter int unsigned DCCM_BITS        = 16,
  parameter int unsigned DCCM_NUM_BANKS   = 8,
  parameter int unsigned DCCM_DATA_WIDTH  = 32,
  parameter int unsigned DCCM_FDATA_WIDTH = 39
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        dccm_wren,
  input  logic                        dccm_rden,
  input  logic [DCCM_BITS-1:0]        dccm_wr_addr,
  input  logic [DCCM_BITS-1:0]        dccm_rd_addr_lo,
  input  logic [DCCM_BITS-1:0]        dccm_rd_addr_hi,
  input  logic [DCCM_FDATA_WIDTH-1:0] dccm_wr_data,
  output logic [DCCM_FDATA_WIDTH-1:0] dccm_rd_data_lo,
  output logic [DCCM_FDATA_WIDTH-1:0] dccm_rd_data_hi,
  output logic                        dccm_init_busy,
  output logic                        dccm_collision_err,
  input  logic                        inj_vld,
  input  logic [DCCM_FDATA_WIDTH-1:0] inj_mask,
  output logic                        inj_pending
);

  localparam int unsigned BANK_BITS = dccm_bank_bits(DCCM_NUM_BANKS);
  localparam int unsigned IDX_BITS  = DCCM_BITS - 2 - BANK_BITS;
  localparam int unsigned DEPTH     = dccm_index_depth(DCCM_BITS, DCCM_NUM_BANKS);
  localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(DEPTH - 1);
  // A zero data word has a zero ECC field, so the clear codeword is all zeros
  localparam logic [DCCM_FDATA_WIDTH-1:0] CLEAR_WORD =
    {(DCCM_FDATA_WIDTH - DCCM_DATA_WIDTH)'(0), DCCM_DATA_WIDTH'(0)};

  dccm_fsm_t             state_q, state_d;
  logic [IDX_BITS-1:0]   cnt_q, cnt_d;
  logic                  busy_q, busy_d;
  logic                  sweep_c, run_c;
  logic [IDX_BITS-1:0]   bank_wr_idx_c;
  logic [DCCM_FDATA_WIDTH-1:0] bank_wr_data_c;

  // Address decode
  logic [BANK_BITS-1:0] wr_bank, lo_bank, hi_bank;
  logic [IDX_BITS-1:0]  wr_idx, lo_idx, hi_idx;
  assign wr_bank = dccm_wr_addr[2 +: BANK_BITS];
  assign lo_bank = dccm_rd_addr_lo[2 +: BANK_BITS];
  assign hi_bank = dccm_rd_addr_hi[2 +: BANK_BITS];
  assign wr_idx  = dccm_wr_addr[DCCM_BITS-1 -: IDX_BITS];
  assign lo_idx  = dccm_rd_addr_lo[DCCM_BITS-1 -: IDX_BITS];
  assign hi_idx  = dccm_rd_addr_hi[DCCM_BITS-1 -: IDX_BITS];

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= INIT;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state and bank write-port steering
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    busy_d         = busy_q;
    sweep_c        = 1'b0;
    run_c          = 1'b0;
    bank_wr_idx_c  = wr_idx;
    bank_wr_data_c = dccm_wr_data;
    case (state_q)
      INIT: begin
        sweep_c        = 1'b1;
        bank_wr_idx_c  = cnt_q;
        bank_wr_data_c = CLEAR_WORD;
        cnt_d          = cnt_q + IDX_BITS'(1);
        if (cnt_q == LAST_IDX) begin
          state_d = RUN;
          busy_d  = 1'b0;
        end
      end
      RUN:     run_c = 1'b1;
      default: state_d = INIT;
    endcase
  end

  logic wr_req, rd_req;
  assign wr_req = run_c & dccm_wren;
  assign rd_req = run_c & dccm_rden;

  logic [DCCM_NUM_BANKS-1:0]   bank_we, bank_re_lo, bank_re_hi;
  logic [DCCM_FDATA_WIDTH-1:0] bank_rd_lo [DCCM_NUM_BANKS];
  logic [DCCM_FDATA_WIDTH-1:0] bank_rd_hi [DCCM_NUM_BANKS];

  for (genvar b = 0; b < DCCM_NUM_BANKS; b++) begin : g_bank
    localparam logic [BANK_BITS-1:0] BID = BANK_BITS'(b);
    assign bank_we[b]    = sweep_c | (wr_req & (wr_bank == BID));
    assign bank_re_lo[b] = rd_req & (lo_bank == BID);
    assign bank_re_hi[b] = rd_req & (hi_bank == BID);

    lsu_dccm_bank #(
      .IDX_BITS (IDX_BITS),
      .DEPTH    (DEPTH),
      .W        (DCCM_FDATA_WIDTH)
    ) u_bank (
      .clk        (clk),
      .rst        (rst),
      .wr_en      (bank_we[b]),
      .wr_idx     (bank_wr_idx_c),
      .wr_data    (bank_wr_data_c),
      .rd_en_lo   (bank_re_lo[b]),
      .rd_idx_lo  (lo_idx),
      .rd_en_hi   (bank_re_hi[b]),
      .rd_idx_hi  (hi_idx),
      .rd_data_lo (bank_rd_lo[b]),
      .rd_data_hi (bank_rd_hi[b])
    );
  end

  // Output bank selects move only on an accepted read, so outputs hold otherwise
  logic [BANK_BITS-1:0] sel_lo_q, sel_hi_q;
  logic                 col_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_lo_q <= '0;
      sel_hi_q <= '0;
      col_q    <= 1'b0;
    end else begin
      if (rd_req) begin
        sel_lo_q <= lo_bank;
        sel_hi_q <= hi_bank;
      end
      col_q <= wr_req & rd_req & ((wr_bank == lo_bank) | (wr_bank == hi_bank));
    end
  end

  logic [DCCM_FDATA_WIDTH-1:0] inj_xor_q;
  logic                        inj_pend_q;

`ifdef RV_DCCM_ECC_INJECT_EN
  logic [DCCM_FDATA_WIDTH-1:0] inj_mask_q;
  // A consuming read uses the old mask even if a new one arms in the same cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inj_mask_q <= '0;
      inj_pend_q <= 1'b0;
      inj_xor_q  <= '0;
    end else if (run_c) begin
      if (dccm_rden) inj_xor_q <= inj_pend_q ? inj_mask_q : '0;
      if (inj_vld) begin
        inj_mask_q <= inj_mask;
        inj_pend_q <= 1'b1;
      end else if (dccm_rden) begin
        inj_pend_q <= 1'b0;
      end
    end
  end
  logic unused_ok;
  assign unused_ok = ^{dccm_wr_addr[1:0], dccm_rd_addr_lo[1:0], dccm_rd_addr_hi[1:0]};
`else
  assign inj_xor_q  = '0;
  assign inj_pend_q = 1'b0;
  logic unused_ok;
  assign unused_ok = ^{dccm_wr_addr[1:0], dccm_rd_addr_lo[1:0], dccm_rd_addr_hi[1:0],
                       inj_vld, inj_mask};
`endif

  assign dccm_rd_data_lo    = bank_rd_lo[sel_lo_q] ^ inj_xor_q;
  assign dccm_rd_data_hi    = bank_rd_hi[sel_hi_q];
  assign dccm_init_busy     = busy_q;
  assign dccm_collision_err = col_q;
  assign inj_pending        = inj_pend_q;

endmodule

// File: tb/tb_lsu_dccm_mem_rsp.sv
// Self-checking bench for lsu_dccm_mem_rsp at DCCM_BITS=8, 4 banks, 16 deep.
// Reference model: a flat 64-word array addressed by byte address / 4.
module tb_lsu_dccm_mem_rsp;
  import lsu_dccm_mem_rsp_pkg::*;

`ifdef RV_DCCM_ECC_INJECT_EN
  localparam bit INJ_ON = 1'b1;
`else
  localparam bit INJ_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       dccm_wren, dccm_rden, inj_vld;
  logic [7:0] dccm_wr_addr, dccm_rd_addr_lo, dccm_rd_addr_hi;
  dccm_word_t dccm_wr_data, inj_mask;
  dccm_word_t dccm_rd_data_lo, dccm_rd_data_hi;
  logic       dccm_init_busy, dccm_collision_err, inj_pending;

  lsu_dccm_mem_rsp #(
    .DCCM_BITS        (8),
    .DCCM_NUM_BANKS   (4),
    .DCCM_DATA_WIDTH  (32),
    .DCCM_FDATA_WIDTH (39)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .dccm_wren          (dccm_wren),
    .dccm_rden          (dccm_rden),
    .dccm_wr_addr       (dccm_wr_addr),
    .dccm_rd_addr_lo    (dccm_rd_addr_lo),
    .dccm_rd_addr_hi    (dccm_rd_addr_hi),
    .dccm_wr_data       (dccm_wr_data),
    .dccm_rd_data_lo    (dccm_rd_data_lo),
    .dccm_rd_data_hi    (dccm_rd_data_hi),
    .dccm_init_busy     (dccm_init_busy),
    .dccm_collision_err (dccm_collision_err),
    .inj_vld            (inj_vld),
    .inj_mask           (inj_mask),
    .inj_pending        (inj_pending)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  dccm_word_t model [64];
  dccm_word_t exp_lo, exp_hi, m_mask;
  logic       exp_col, m_pend;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int bank_of(input logic [7:0] a);
    return (int'(a) / 4) % 4;
  endfunction

  task automatic idle_inputs();
    dccm_wren = 1'b0; dccm_rden = 1'b0; inj_vld = 1'b0;
    dccm_wr_addr = '0; dccm_rd_addr_lo = '0; dccm_rd_addr_hi = '0;
    dccm_wr_data = '0; inj_mask = '0;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 64; i++) model[i] = '0;
    exp_lo = '0; exp_hi = '0; exp_col = 1'b0; m_pend = 1'b0; m_mask = '0;
  endtask

  // Count busy cycles from release; requests are thrown at the DUT meanwhile
  task automatic sweep_and_count(input string tag);
    int cyc = 0;
    while (dccm_init_busy === 1'b1 && cyc < 100) begin
      cyc++;
      dccm_wren = 1'b1; dccm_wr_addr = 8'($urandom_range(0, 255));
      dccm_wr_data = 39'({$urandom(), $urandom()}) | 39'h1;
      dccm_rden = 1'b1; dccm_rd_addr_lo = 8'($urandom_range(0, 255));
      dccm_rd_addr_hi = dccm_rd_addr_lo;
      inj_vld = 1'b1; inj_mask = 39'h55;
      @(negedge clk);
      check({tag, ".busy_col"}, 64'(dccm_collision_err), 64'd0);
      check({tag, ".busy_lo"}, 64'(dccm_rd_data_lo), 64'd0);
    end
    idle_inputs();
    check({tag, ".busy_cycles"}, 64'(cyc), 64'd16);
    check({tag, ".pend_after"}, 64'(inj_pending), 64'd0);
  endtask

  task automatic step(input logic we, input logic [7:0] wa, input dccm_word_t wd,
                      input logic re, input logic [7:0] la, input logic [7:0] ha,
                      input logic iv, input dccm_word_t im, input string tag);
    dccm_wren = we; dccm_wr_addr = wa; dccm_wr_data = wd;
    dccm_rden = re; dccm_rd_addr_lo = la; dccm_rd_addr_hi = ha;
    inj_vld = iv; inj_mask = im;
    if (re) begin
      exp_lo = model[la[7:2]] ^ ((INJ_ON && m_pend) ? m_mask : '0);
      exp_hi = model[ha[7:2]];
      m_pend = 1'b0;
    end
    exp_col = we && re && (bank_of(wa) == bank_of(la) || bank_of(wa) == bank_of(ha));
    if (INJ_ON && iv) begin
      m_pend = 1'b1;
      m_mask = im;
    end
    if (we) model[wa[7:2]] = wd;
    @(negedge clk);
    check({tag, ".lo"},   64'(dccm_rd_data_lo),    64'(exp_lo));
    check({tag, ".hi"},   64'(dccm_rd_data_hi),    64'(exp_hi));
    check({tag, ".col"},  64'(dccm_collision_err), 64'(exp_col));
    check({tag, ".pend"}, 64'(inj_pending),        64'(m_pend));
    check({tag, ".busy"}, 64'(dccm_init_busy),     64'd0);
  endtask

  localparam dccm_word_t Z  = '0;
  localparam dccm_word_t DA = 39'h7F_DEADBEEF;
  localparam dccm_word_t WA = 39'h12_3456789A;
  localparam dccm_word_t WB = 39'h45_0BADF00D;

  initial begin
    idle_inputs();
    rst = 1'b1;
    model_clear();
    repeat (3) @(negedge clk);
    check("rst.busy", 64'(dccm_init_busy), 64'd1);
    check("rst.lo", 64'(dccm_rd_data_lo), 64'd0);
    check("rst.hi", 64'(dccm_rd_data_hi), 64'd0);
    check("rst.col", 64'(dccm_collision_err), 64'd0);
    check("rst.pend", 64'(inj_pending), 64'd0);
    rst = 1'b0;
    sweep_and_count("init");

    // Busy-time writes were dropped; memory reads back as zero
    step(0, 8'h00, Z, 1, 8'h00, 8'h00, 0, Z, "t1.rd0");
    step(0, 8'h00, Z, 1, 8'h24, 8'hF0, 0, Z, "t1.rdx");

    step(1, 8'h14, DA, 0, 8'h00, 8'h00, 0, Z, "t2.wr");
    step(0, 8'h00, Z, 1, 8'h14, 8'h17, 0, Z, "t2.rd");
    step(0, 8'h00, Z, 0, 8'h30, 8'h40, 0, Z, "t2.hold");

    step(1, 8'h0C, WA, 0, 8'h00, 8'h00, 0, Z, "t3.wa");
    step(1, 8'h10, WB, 0, 8'h00, 8'h00, 0, Z, "t3.wb");
    step(0, 8'h00, Z, 1, 8'h0E, 8'h11, 0, Z, "t3.rd");

    step(1, 8'h04, WA, 0, 8'h00, 8'h00, 0, Z, "t4.wa");
    step(1, 8'h04, WB, 1, 8'h04, 8'h04, 0, Z, "t4.coll");
    step(0, 8'h00, Z, 1, 8'h04, 8'h04, 0, Z, "t4.reread");
    step(1, 8'h08, WA, 1, 8'h04, 8'h04, 0, Z, "t4.nocoll");
    step(1, 8'h08, WB, 1, 8'h04, 8'h08, 0, Z, "t4.hicoll");

`ifdef RV_DCCM_ECC_INJECT_EN
    step(0, 8'h00, Z, 0, 8'h00, 8'h00, 1, 39'h1, "t6.arm");
    step(0, 8'h00, Z, 1, 8'h14, 8'h14, 0, Z, "t6.inj");
    step(0, 8'h00, Z, 1, 8'h14, 8'h14, 0, Z, "t6.clean");
    step(0, 8'h00, Z, 0, 8'h00, 8'h00, 1, 39'h3, "t6.arm2");
    step(0, 8'h00, Z, 1, 8'h14, 8'h14, 1, 39'h100, "t6.rearm");
    step(0, 8'h00, Z, 1, 8'h10, 8'h14, 0, Z, "t6.second");
`endif

    // Randomized traffic; hi is either the same word as lo or the next word
    for (int i = 0; i < 600; i++) begin
      logic [7:0] wa, la, ha;
      wa = 8'($urandom_range(0, 255));
      la = 8'($urandom_range(0, 255));
      ha = ($urandom_range(0, 1) == 0) ? la : 8'(la + 8'd4);
      if ($urandom_range(0, 3) == 0) wa = la;
      step(1'($urandom_range(0, 1)), wa, 39'({$urandom(), $urandom()}),
           1'($urandom_range(0, 2) != 0), la, ha,
           1'($urandom_range(0, 7) == 0), 39'({$urandom(), $urandom()}), "rnd");
    end

    // Reset mid-sweep: sweep restarts from index 0
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    repeat (7) @(negedge clk);
    check("t5.midbusy", 64'(dccm_init_busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check("t5.rstbusy", 64'(dccm_init_busy), 64'd1);
    rst = 1'b0;
    sweep_and_count("t5");
    step(0, 8'h00, Z, 1, 8'h14, 8'h0C, 0, Z, "t5.cleared");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_dccm_mem_rsp.md
Name: lsu_dccm_mem_rsp

Overview:
Responder end of the LSU DCCM port: a banked, ECC-word-wide DCCM storage model that accepts the controller's one write and two reads (lo/hi) per cycle, and returns read data one cycle later. The LSU DCCM controller is the initiator on the other side. After reset, an internal sweep clears every word to a valid all-zero codeword. The block also flags read/write bank collisions for verification.

Parameters:
DCCM_BITS, 16, byte-address width of DCCM
DCCM_NUM_BANKS, 8, number of 32-bit banks (power of 2, >=2)
DCCM_DATA_WIDTH, 32, data bits per word
DCCM_FDATA_WIDTH, 39, data+ECC bits per word ({ecc[6:0],data[31:0]})

Ports:
clk  in  1  core clock
rst  in  1  asynchronous active-high reset
dccm_wren  in  1  write enable
dccm_rden  in  1  read enable (both lo and hi)
dccm_wr_addr  in  DCCM_BITS  write byte address
dccm_rd_addr_lo  in  DCCM_BITS  read address, lo word
dccm_rd_addr_hi  in  DCCM_BITS  read address, hi word
dccm_wr_data  in  DCCM_FDATA_WIDTH  write word incl. ECC
dccm_rd_data_lo  out  DCCM_FDATA_WIDTH  lo read data
dccm_rd_data_hi  out  DCCM_FDATA_WIDTH  hi read data
dccm_init_busy  out  1  clear sweep in progress
dccm_collision_err  out  1  registered flag: same-bank read+write in the same cycle
inj_vld  in  1  ECC-inject arm (feature only)
inj_mask  in  DCCM_FDATA_WIDTH  XOR mask for injection (feature only)
inj_pending  out  1  injection armed, not yet consumed

Behaviour:
- Address decode: BANK_BITS=log2(DCCM_NUM_BANKS). The bank is addr[2+:BANK_BITS]. The index is addr[DCCM_BITS-1:2+BANK_BITS]. DEPTH=2^(DCCM_BITS-2-BANK_BITS). addr[1:0] is ignored.
- Reset values: all outputs 0 except dccm_init_busy=1. The FSM enters INIT with the index counter at 0.
- FSM states:
  - INIT: each cycle, write 0 to index cnt in all banks, then cnt++. Transition to RUN in the cycle after cnt==DEPTH-1 is written. dccm_init_busy deasserts in the first RUN cycle.
  - RUN: normal operation.
  - There is no return to INIT except via rst. If rst asserts mid-sweep, the counter returns to 0 and the sweep restarts.
- During INIT:
  - Requests are ignored: wren is dropped and rden does not update the outputs.
  - dccm_collision_err stays 0.
- Writes: the word is stored at the rising edge of the cycle in which wren=1.
- Reads: latency 1.
  - rden in cycle N presents data at dccm_rd_data_lo/hi in cycle N+1, registered.
  - When rden=0, the outputs hold their last value.
- Lo and hi reads that map to the same bank and the same index return identical data. This is legal and covers the aligned case.
- Lo and hi reads that map to the same bank with different indices cannot occur with NUM_BANKS>=2. There is no check for it.
- Simultaneous write and read:
  - Read returns the old (pre-write) contents of that index.
  - If the write bank equals the lo or hi read bank, dccm_collision_err=1 in cycle N+1; otherwise 0.
  - The write still completes.
- Wrap-around: addresses beyond the DCCM are truncated to DCCM_BITS by the port widths. No range checking.

Optional Feature:
Macro: RV_DCCM_ECC_INJECT_EN.
- With the macro defined:
  - inj_vld=1 in RUN latches inj_mask and sets inj_pending.
  - The next rden XORs the mask into dccm_rd_data_lo only, then clears inj_pending.
  - Stored memory is unchanged.
  - inj_vld in the same cycle as the consuming rden: the old mask is consumed and the new mask is armed.
- Without the macro: inj_* inputs are ignored and inj_pending ties to 0.

Decomposition:
- Shared package (swerv_types or global header):
  - DCCM_BANK_BITS and DCCM_INDEX_DEPTH localparam derivations
  - dccm_fsm_t enum {INIT, RUN}
  - dccm_word_t typedef (FDATA_WIDTH)
- One sub-module, lsu_dccm_bank:
  - single bank, DEPTH x FDATA storage
  - one write port, up to two read ports (lo/hi), registered output
  - instantiated DCCM_NUM_BANKS times with generate
- The top level holds the FSM, decode, collision detect, output muxing and injection.

Test Plan (DCCM_BITS=8, NUM_BANKS=4, DEPTH=16):
1. Release rst -> dccm_init_busy high for exactly 16 cycles, then low. A read of 0x00 issued right after then returns 39'h0. A wren during busy, followed by a read after busy, returns 0.
2. Write 0x14 with data 39'h7F_DEADBEEF, then rden lo=0x14, hi=0x17 next cycle -> both outputs 39'h7F_DEADBEEF one cycle later. With rden=0 the following cycle, outputs hold.
3. Unaligned read lo=0x0E, hi=0x11 after writing A to 0x0C and B to 0x10 -> lo=A, hi=B.
4. Same-cycle write B to 0x04 and read lo=0x04 (old value A) -> rd_data_lo=A and dccm_collision_err=1. Re-reading 0x04 returns B. A write to 0x08 with a read of 0x04 gives collision_err=0.
5. Assert rst at sweep count 7, release -> dccm_init_busy lasts a full 16 more cycles.
6. With RV_DCCM_ECC_INJECT_EN: inj_vld with mask 39'h1, then read of word X -> lo=X^1, hi=X, inj_pending 1->0. A second read returns X.
